// File: rtl/axi4lite_master_arbiter.sv
// rtl/axi4lite_master_arbiter.sv - round-robin sharing of one AXI4-Lite master port among NUM_REQ requesters
// Define AXI4L_ARB_TIMEOUT_EN to add the sticky timeout_err watchdog output.
module axi4lite_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int axi_bit        = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*axi_bit-1:0]     req_addr,
  input  logic [NUM_REQ*axi_bit-1:0]     req_wdata,
  input  logic [NUM_REQ*(axi_bit/8)-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]             ack,
  output logic [axi_bit-1:0]             rsp_data,
  output logic [1:0]                     rsp_resp,
  output logic [axi_bit-1:0]             ARADDR,
  output logic [2:0]                     ARPROT,
  output logic [3:0]                     ARCACHE,
  output logic                           ARVALID,
  input  logic                           ARREADY,
  input  logic [axi_bit-1:0]             RDATA,
  input  logic [1:0]                     RRESP,
  input  logic                           RVALID,
  output logic                           RREADY,
  output logic [axi_bit-1:0]             AWADDR,
  output logic [2:0]                     AWPROT,
  output logic [3:0]                     AWCACHE,
  output logic                           AWVALID,
  input  logic                           AWREADY,
  output logic [axi_bit-1:0]             WDATA,
  output logic [axi_bit/8-1:0]           WSTRB,
  output logic                           WVALID,
  input  logic                           WREADY,
  input  logic [1:0]                     BRESP,
  input  logic                           BVALID,
  output logic                           BREADY,
  output logic                           read_or_write,
  output logic                           busy
`ifdef AXI4L_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_err
`endif
);

  localparam int SW = axi_bit / 8;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (axi_bit != 32 && axi_bit != 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("axi4lite_master_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_RESP, DONE} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic [axi_bit-1:0] addr_q, addr_d;
  logic [axi_bit-1:0] wdata_q, wdata_d;
  logic [SW-1:0]      wstrb_q, wstrb_d;
  logic               we_q, we_d;
  logic [axi_bit-1:0] rdata_q, rdata_d;
  logic [1:0]         resp_q, resp_d;
  logic               arvalid_q, arvalid_d;
  logic               rready_q, rready_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               bready_q, bready_d;

  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  int                 cand;

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!pick_found && req[IW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          addr_d  = req_addr[int'(pick_idx)*axi_bit +: axi_bit];
          wdata_d = req_wdata[int'(pick_idx)*axi_bit +: axi_bit];
          wstrb_d = req_wstrb[int'(pick_idx)*SW +: SW];
          we_d    = req_we[pick_idx];
          if (req_we[pick_idx]) begin
            state_d   = WR_AW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_A;
            arvalid_d = 1'b1;
          end
        end
      end
      RD_A: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_D;
        end
      end
      RD_D: begin
        if (RVALID && rready_q) begin
          rdata_d  = RDATA;
          resp_d   = RRESP;
          rready_d = 1'b0;
          state_d  = DONE;
        end
      end
      WR_AW: begin
        // AW and W retire independently; move on once neither is still pending.
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (BVALID && bready_q) begin
          resp_d   = BRESP;
          rdata_d  = '0;
          bready_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        rr_ptr_d = IW'((int'(grant_q) + 1) % NUM_REQ);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
    end
  end

  assign ack           = (state_q == DONE) ? (NUM_REQ'(1) << grant_q) : '0;
  assign busy          = (state_q != IDLE);
  assign read_or_write = we_q;
  assign rsp_data      = rdata_q;
  assign rsp_resp      = resp_q;
  assign ARADDR        = addr_q;
  assign ARPROT        = 3'b000;
  assign ARCACHE       = 4'b0000;
  assign ARVALID       = arvalid_q;
  assign RREADY        = rready_q;
  assign AWADDR        = addr_q;
  assign AWPROT        = 3'b000;
  assign AWCACHE       = 4'b0000;
  assign AWVALID       = awvalid_q;
  assign WDATA         = wdata_q;
  assign WSTRB         = wstrb_q;
  assign WVALID        = wvalid_q;
  assign BREADY        = bready_q;

`ifdef AXI4L_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_err_q, timeout_err_d;

  // Flag only; VALIDs must stay up until the slave responds.
  always_comb begin
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
    if (state_q == IDLE && pick_found) begin
      to_cnt_d = '0;
    end else if ((state_q == RD_A || state_q == RD_D || state_q == WR_AW || state_q == WR_RESP) &&
                 to_cnt_q != TW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    if (to_cnt_d == TW'(TIMEOUT_CYCLES)) timeout_err_d = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// tb/tb_axi4lite_master_arbiter.sv - directed and randomized self-checking bench for axi4lite_master_arbiter
// Exercises the AXI4L_ARB_TIMEOUT_EN watchdog when that macro is defined.
module tb_axi4lite_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int SW = AW / 8;
  localparam int TO = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic [N-1:0]      req, req_we, ack;
  logic [N*AW-1:0]   req_addr, req_wdata;
  logic [N*SW-1:0]   req_wstrb;
  logic [AW-1:0]     rsp_data, ARADDR, RDATA, AWADDR, WDATA;
  logic [1:0]        rsp_resp, RRESP, BRESP;
  logic [2:0]        ARPROT, AWPROT;
  logic [3:0]        ARCACHE, AWCACHE;
  logic [SW-1:0]     WSTRB;
  logic              ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY;
  logic              WVALID, WREADY, BVALID, BREADY, read_or_write, busy;
`ifdef AXI4L_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  logic [AW-1:0]     r_addr  [N];
  logic [AW-1:0]     r_wdata [N];
  logic [SW-1:0]     r_wstrb [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_addr[i*AW +: AW]  = r_addr[i];
    assign req_wdata[i*AW +: AW] = r_wdata[i];
    assign req_wstrb[i*SW +: SW] = r_wstrb[i];
  end

  always #5 PCLK = ~PCLK;

  axi4lite_master_arbiter #(.NUM_REQ(N), .axi_bit(AW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .ack(ack), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARCACHE(ARCACHE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWCACHE(AWCACHE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .read_or_write(read_or_write), .busy(busy)
`ifdef AXI4L_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  int tests  = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Random-phase state: requester knobs, reference model, slave model.
  bit            eng_on = 0, eng_raise = 0, all_req = 0;
  int            m_ptr, m_g, m_wait, prev_g;
  bit            m_busy, m_idle, m_skip, prev_valid;
  bit            m_we;
  logic [AW-1:0] m_addr, m_wdata;
  logic [SW-1:0] m_wstrb;
  int            acks;
  bit            s_dir, s_r_pend, s_b_pend, s_aw_got, s_w_got;
  int            s_ar_lat, s_r_lat, s_aw_lat, s_w_lat, s_b_lat;
  logic [AW-1:0] s_addr, s_wdata, s_rdata;
  logic [SW-1:0] s_wstrb;
  logic [1:0]    s_resp;

  task automatic new_cmd(input int i);
    req_we[i]  = 1'($urandom_range(1));
    r_addr[i]  = $urandom & 32'hFFFF_FFFC;
    r_wdata[i] = $urandom;
    r_wstrb[i] = SW'($urandom);
    req[i]     = 1'b1;
  endtask

  task automatic eng_init();
    m_ptr = 0; m_busy = 0; m_idle = 1; m_skip = 0; m_wait = 0; prev_valid = 0; acks = 0;
    s_r_pend = 0; s_b_pend = 0; s_aw_got = 0; s_w_got = 0;
    s_ar_lat = 0; s_r_lat = 0; s_aw_lat = 0; s_w_lat = 0; s_b_lat = 0;
  endtask

  task automatic eng_step();
    if (ack != '0) begin
      if (!m_busy) begin
        check_eq("ack_unexpected", 64'(ack), 64'(0));
      end else begin
        check_eq("ack_who", 64'(ack), 64'(1) << m_g);
        check_eq("bus_dir", 64'(s_dir), 64'(m_we));
        check_eq("bus_addr", 64'(s_addr), 64'(m_addr));
        if (m_we) begin
          check_eq("bus_wdata", 64'(s_wdata), 64'(m_wdata));
          check_eq("bus_wstrb", 64'(s_wstrb), 64'(m_wstrb));
        end
        check_eq("rsp_data", 64'(rsp_data), m_we ? 64'(0) : 64'(s_rdata));
        check_eq("rsp_resp", 64'(rsp_resp), 64'(s_resp));
        if (all_req && prev_valid) check_eq("rr_no_repeat", 64'(m_g != prev_g), 64'(1));
        prev_g = m_g; prev_valid = 1; acks++;
        m_ptr = (m_g + 1) % N; m_busy = 0; m_idle = 1; m_skip = 1;
        if (all_req || (eng_raise && $urandom_range(3) == 0)) new_cmd(m_g);
        else req[m_g] = 1'b0;
      end
    end
    if (m_busy) begin
      m_wait++;
      if (m_wait > 200) begin
        check_eq("ack_wait", 64'(m_wait), 64'(200));
        m_busy = 0; m_idle = 1;
      end
    end
    // Requesters: raise new commands, and scramble the granted one's fields.
    for (int i = 0; i < N; i++) begin
      if (!req[i] && (all_req || (eng_raise && $urandom_range(3) == 0))) new_cmd(i);
      else if (m_busy && i == m_g && $urandom_range(1) == 1) begin
        req_we[i]  = ~req_we[i];
        r_addr[i]  = $urandom;
        r_wdata[i] = $urandom;
        r_wstrb[i] = SW'($urandom);
      end
    end
    // Reference model: round-robin over whatever is pending when the arbiter is idle.
    if (m_idle && !m_skip && req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (m_idle && req[(m_ptr + k) % N]) begin
          m_g = (m_ptr + k) % N;
          m_we = req_we[m_g]; m_addr = r_addr[m_g]; m_wdata = r_wdata[m_g]; m_wstrb = r_wstrb[m_g];
          m_busy = 1; m_idle = 0; m_wait = 0;
        end
      end
    end
    m_skip = 0;
    // Slave: response channels first so a response never precedes its request.
    RVALID = 1'b0;
    if (s_r_pend) begin
      if (s_r_lat == 0) begin
        RVALID = 1'b1; RDATA = s_rdata; RRESP = s_resp;
        if (RREADY) s_r_pend = 0;
      end else s_r_lat--;
    end
    BVALID = 1'b0;
    if (s_b_pend) begin
      if (s_b_lat == 0) begin
        BVALID = 1'b1; BRESP = s_resp;
        if (BREADY) s_b_pend = 0;
      end else s_b_lat--;
    end
    ARREADY = 1'b0;
    if (ARVALID) begin
      if (s_ar_lat == 0) begin
        ARREADY = 1'b1; s_addr = ARADDR; s_dir = 0; s_r_pend = 1;
        s_r_lat = $urandom_range(3); s_rdata = $urandom; s_resp = 2'($urandom);
        s_ar_lat = $urandom_range(3);
      end else s_ar_lat--;
    end
    AWREADY = 1'b0;
    if (AWVALID && !s_aw_got) begin
      if (s_aw_lat == 0) begin
        AWREADY = 1'b1; s_addr = AWADDR; s_dir = 1; s_aw_got = 1; s_aw_lat = $urandom_range(3);
      end else s_aw_lat--;
    end
    WREADY = 1'b0;
    if (WVALID && !s_w_got) begin
      if (s_w_lat == 0) begin
        WREADY = 1'b1; s_wdata = WDATA; s_wstrb = WSTRB; s_w_got = 1; s_w_lat = $urandom_range(3);
      end else s_w_lat--;
    end
    if (s_aw_got && s_w_got) begin
      s_aw_got = 0; s_w_got = 0; s_b_pend = 1;
      s_b_lat = $urandom_range(3); s_resp = 2'($urandom);
    end
  endtask

  initial begin
    forever begin
      @(negedge PCLK);
      if (eng_on) eng_step();
    end
  end

  task automatic do_reset();
    @(negedge PCLK);
    PRESETn = 1'b0; req = '0; req_we = '0;
    ARREADY = 0; RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
    RDATA = '0; RRESP = '0; BRESP = '0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  int cyc, cnt_a, cnt_b, bad, seen;

  initial begin
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_wdata[i] = '0; r_wstrb[i] = '0; end
    do_reset();
    check_eq("rst_valids", 64'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 64'(0));
    check_eq("rst_ack_busy_dir", 64'({ack, busy, read_or_write}), 64'(0));
    check_eq("rst_rsp", 64'({rsp_data, rsp_resp}), 64'(0));
    check_eq("rst_addr_data", 64'({ARADDR, WDATA}), 64'(0));
    check_eq("prot_cache", 64'({ARPROT, ARCACHE, AWPROT, AWCACHE}), 64'(0));

    // Single read, everything ready: ack in the 4th cycle counting the req cycle.
    @(negedge PCLK);
    req_we[0] = 0; r_addr[0] = 32'h10; req[0] = 1;
    ARREADY = 1; RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = 2'b00;
    cyc = 1; seen = 0;
    while (ack == '0 && cyc < 20) begin
      if (ARVALID) seen = int'(ARADDR);
      @(negedge PCLK); cyc++;
    end
    check_eq("rd_latency", 64'(cyc), 64'(4));
    check_eq("rd_araddr", 64'(seen), 64'h10);
    check_eq("rd_ack", 64'(ack), 64'b01);
    check_eq("rd_data", 64'(rsp_data), 64'hDEAD_BEEF);
    check_eq("rd_resp", 64'(rsp_resp), 64'(0));
    req[0] = 0; RVALID = 0;
    @(negedge PCLK);
    check_eq("rd_ack_pulse", 64'({ack, busy}), 64'(0));

    // Write with AWREADY held off for three AWVALID cycles, WREADY immediate.
    req_we[0] = 1; r_addr[0] = 32'h20; r_wdata[0] = 32'h1234_5678; r_wstrb[0] = 4'hF; req[0] = 1;
    WREADY = 1; AWREADY = 0; BVALID = 1; BRESP = 2'b00;
    cyc = 1; cnt_a = 0; cnt_b = 0; bad = 0;
    while (ack == '0 && cyc < 30) begin
      if (AWVALID) begin
        cnt_a++;
        if (AWADDR != 32'h20 || !read_or_write) bad++;
      end
      if (WVALID) begin
        cnt_b++;
        if (WDATA != 32'h1234_5678 || WSTRB != 4'hF) bad++;
      end
      AWREADY = (cnt_a >= 3);
      @(negedge PCLK); cyc++;
    end
    check_eq("wr_awvalid_cycles", 64'(cnt_a), 64'(3));
    check_eq("wr_wvalid_cycles", 64'(cnt_b), 64'(1));
    check_eq("wr_bus_fields", 64'(bad), 64'(0));
    check_eq("wr_ack_cycle", 64'(cyc), 64'(6));
    check_eq("wr_ack", 64'(ack), 64'b01);
    check_eq("wr_rsp", 64'({rsp_data, rsp_resp}), 64'(0));
    req[0] = 0; BVALID = 0; AWREADY = 0; WREADY = 0;
    @(negedge PCLK);

    // Read back-pressure on requester 1; its inputs are scrambled after grant.
    req_we[1] = 0; r_addr[1] = 32'h44; req[1] = 1;
    ARREADY = 0; RVALID = 0; RDATA = 32'hCAFE_F00D; RRESP = 2'b01;
    cyc = 1; cnt_a = 0; cnt_b = 0; bad = 0;
    while (ack == '0 && cyc < 60) begin
      if (ARVALID) begin
        cnt_a++;
        if (ARADDR != 32'h44) bad++;
      end
      if (cyc >= 2) begin r_addr[1] = $urandom; req_we[1] = 1'($urandom_range(1)); end
      ARREADY = (cnt_a >= 5);
      if (RREADY) cnt_b++;
      RVALID = (cnt_b > 10);
      @(negedge PCLK); cyc++;
    end
    check_eq("bp_araddr_stable", 64'(bad), 64'(0));
    check_eq("bp_arvalid_cycles", 64'(cnt_a), 64'(5));
    check_eq("bp_rready_cycles", 64'(cnt_b), 64'(11));
    check_eq("bp_ack_cycle", 64'(cyc), 64'(18));
    check_eq("bp_ack", 64'(ack), 64'b10);
    check_eq("bp_data_resp", 64'({rsp_data, rsp_resp}), {30'd0, 32'hCAFE_F00D, 2'b01});
    req[1] = 0; RVALID = 0; ARREADY = 0;
    @(negedge PCLK);

    // Write returning SLVERR.
    req_we[0] = 1; r_addr[0] = 32'h30; r_wdata[0] = 32'hA5A5_0001; r_wstrb[0] = 4'h3; req[0] = 1;
    AWREADY = 1; WREADY = 1; BVALID = 1; BRESP = 2'b10;
    cyc = 1;
    while (ack == '0 && cyc < 20) begin @(negedge PCLK); cyc++; end
    check_eq("err_latency", 64'(cyc), 64'(4));
    check_eq("err_ack_resp", 64'({ack, rsp_resp}), {60'd0, 2'b01, 2'b10});
    req[0] = 0; BVALID = 0;
    @(negedge PCLK);

    // Reset while waiting for B: no ack may follow.
    req_we[1] = 1; r_addr[1] = 32'h50; req[1] = 1; BVALID = 0;
    cyc = 0;
    while (!BREADY && cyc < 20) begin @(negedge PCLK); cyc++; end
    check_eq("rst_mid_reached_bready", 64'(BREADY), 64'(1));
    PRESETn = 0;
    @(negedge PCLK);
    check_eq("rst_mid_valids", 64'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 64'(0));
    check_eq("rst_mid_ack_busy", 64'({ack, busy}), 64'(0));
    PRESETn = 1; req = '0; AWREADY = 0; WREADY = 0;
    seen = 0;
    repeat (6) begin @(negedge PCLK); if (ack != '0) seen++; end
    check_eq("rst_mid_no_ack", 64'(seen), 64'(0));

    // Randomized traffic against the reference model.
    do_reset();
    eng_init();
    @(posedge PCLK);
    eng_raise = 1; eng_on = 1;
    repeat (1500) @(posedge PCLK);
    eng_raise = 0;
    cyc = 0;
    while ((m_busy || req != '0) && cyc < 500) begin @(posedge PCLK); cyc++; end
    check_eq("rand_drained", 64'({m_busy, req}), 64'(0));
    check_eq("rand_some_acks", 64'(acks > 20), 64'(1));

    // Continuous contention: grants must alternate.
    prev_valid = 0; acks = 0; all_req = 1;
    repeat (120) @(posedge PCLK);
    all_req = 0;
    cyc = 0;
    while ((m_busy || req != '0) && cyc < 500) begin @(posedge PCLK); cyc++; end
    check_eq("cont_drained", 64'({m_busy, req}), 64'(0));
    check_eq("cont_some_acks", 64'(acks > 10), 64'(1));
    eng_on = 0;

`ifdef AXI4L_ARB_TIMEOUT_EN
    do_reset();
    check_eq("to_rst", 64'(timeout_err), 64'(0));
    @(negedge PCLK);
    req_we[0] = 0; r_addr[0] = 32'h60; req[0] = 1; ARREADY = 0;
    cnt_a = 0;
    while (!timeout_err && cnt_a < 40) begin
      @(negedge PCLK);
      if (ARVALID) cnt_a++;
    end
    check_eq("to_cycle", 64'(cnt_a), 64'(TO + 1));
    check_eq("to_arvalid_held", 64'({ARVALID, ack}), 64'b100);
    repeat (3) @(negedge PCLK);
    check_eq("to_sticky", 64'(timeout_err), 64'(1));
    do_reset();
    check_eq("to_cleared", 64'(timeout_err), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
